// File: rtl/tb_status_periph.sv
// Simulation status responder: buffers stdout characters toward the host and
// latches pass/fail/exit results, releasing them only once stdout has drained.
module tb_status_periph #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] PASS_MAGIC = 32'd123456789
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        stdout_valid_o,
  output logic [7:0]  stdout_char_o,
  input  logic        stdout_ready_i,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  localparam logic [4:0] OFF_PRINT  = 5'h00;
  localparam logic [4:0] OFF_STATUS = 5'h04;
  localparam logic [4:0] OFF_RESULT = 5'h08;
  localparam logic [4:0] OFF_EXIT   = 5'h0C;
  localparam logic [4:0] OFF_CYCLES = 5'h10;

  typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_DONE} state_e;
  typedef enum logic [1:0] {FIN_PASS, FIN_FAIL, FIN_EXIT} fin_e;

  typedef struct packed {
    logic       hit;
    logic [4:0] off;
    logic       we;
  } dec_t;

  dec_t        dec;
  logic        print_wr, fin_wr, push, pop, full, empty;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q;
  logic [31:0] cycles_q;
  logic [31:0] rd_data;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  state_e      state_q, state_d;
  fin_e        kind_q, kind_d;
  logic        capture;
  logic [31:0] exit_val_q;
  logic        unused_be;

  assign unused_be = ^data_be_i[3:1];

  // Request decode
  always_comb begin
    dec.hit = (data_addr_i[31:5] == BASE_ADDR[31:5]);
    dec.off = data_addr_i[4:0];
    dec.we  = data_we_i;
  end

  assign full     = (level_q == LW'(FIFO_DEPTH));
  assign empty    = (level_q == '0);
  assign print_wr = dec.hit & dec.we & (dec.off == OFF_PRINT);
  // A full FIFO stalls PRINT using the pre-pop flag: no same-cycle bypass.
  assign data_gnt_o = data_req_i & dec.hit & ~(print_wr & full);
  assign push     = data_gnt_o & print_wr & data_be_i[0];
  assign pop      = ~empty & stdout_ready_i;
  assign fin_wr   = data_gnt_o & dec.we &
                    ((dec.off == OFF_RESULT) | (dec.off == OFF_EXIT));

  // Stdout FIFO
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr_q] <= data_wdata_i[7:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  assign stdout_valid_o = ~empty;
  assign stdout_char_o  = empty ? 8'h00 : mem[rptr_q];

  // Free-running cycle counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cycles_q <= '0;
    else         cycles_q <= cycles_q + 32'd1;
  end

  // Read data mux; writes and unmapped offsets read as zero
  always_comb begin
    rd_data = '0;
    if (!dec.we) begin
      case (dec.off)
        OFF_STATUS: rd_data = {23'b0, full, 8'(level_q)};
        OFF_CYCLES: rd_data = cycles_q;
        default:    rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= data_gnt_o;
      rdata_q  <= data_gnt_o ? rd_data : 32'd0;
    end
  end

  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;

  // Completion FSM: only the first RESULT/EXIT write counts
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fin_wr) begin
          capture = 1'b1;
          if (dec.off == OFF_EXIT)                kind_d = FIN_EXIT;
          else if (data_wdata_i == PASS_MAGIC)    kind_d = FIN_PASS;
          else                                    kind_d = FIN_FAIL;
          state_d = empty ? ST_DONE : ST_PENDING;
        end
      end
      ST_PENDING: if (empty) state_d = ST_DONE;
      ST_DONE:    state_d = ST_DONE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      kind_q     <= FIN_PASS;
      exit_val_q <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      if (capture && dec.off == OFF_EXIT) exit_val_q <= data_wdata_i;
    end
  end

  assign tests_passed_o = (state_q == ST_DONE) && (kind_q == FIN_PASS);
  assign tests_failed_o = (state_q == ST_DONE) && (kind_q == FIN_FAIL);
  assign exit_valid_o   = (state_q == ST_DONE) && (kind_q == FIN_EXIT);
  assign exit_value_o   = exit_valid_o ? exit_val_q : 32'd0;

endmodule

// File: tb/tb_tb_status_periph.sv
// Bench for tb_status_periph: directed scenarios plus random traffic, every
// cycle checked against a queue-based model of the register/FIFO/flag rules.
module tb_tb_status_periph;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 16;
  localparam logic [31:0] MAGIC = 32'd123456789;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        req = 1'b0, we = 1'b0, ready = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic        gnt, rvalid, sv, passed, failed, exit_valid;
  logic [31:0] rdata, exit_value;
  logic [7:0]  ch;

  tb_status_periph #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .PASS_MAGIC(MAGIC)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .data_req_i(req), .data_addr_i(addr), .data_we_i(we), .data_be_i(be),
    .data_wdata_i(wdata), .data_gnt_o(gnt), .data_rvalid_o(rvalid),
    .data_rdata_o(rdata), .stdout_valid_o(sv), .stdout_char_o(ch),
    .stdout_ready_i(ready), .tests_passed_o(passed), .tests_failed_o(failed),
    .exit_valid_o(exit_valid), .exit_value_o(exit_value)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, failures = 0;

  // Reference model state
  logic [7:0]  mq[$];
  logic [7:0]  emitted[$];
  int unsigned mcyc;
  bit          armed, done;
  int          kind;  // 1 pass, 2 fail, 3 exit
  logic [31:0] mexit;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set(input logic r, input logic [31:0] a, input logic w,
                     input logic [3:0] b, input logic [31:0] d);
    req = r; addr = a; we = w; be = b; wdata = d;
  endtask

  // One clock cycle: check combinational outputs, advance model, check registered outputs.
  task automatic step();
    logic [31:0] off, erd, wd;
    bit eg, prwr, fin, w, b0;
    int sz;
    logic [7:0] dch;
    #1;
    off = addr - BASE; sz = mq.size(); w = we; wd = wdata; b0 = be[0];
    prwr = w && off == 0;
    eg = req && (off < 32) && !(prwr && sz == DEPTH);
    chk("gnt", gnt, eg);
    chk("stdout_valid", sv, sz != 0);
    if (sz != 0) chk("stdout_char", ch, mq[0]);
    dch = ch;
    erd = 0;
    if (eg && !w) begin
      if (off == 4)  erd = sz + ((sz == DEPTH) ? 256 : 0);
      if (off == 16) erd = mcyc;
    end
    fin = eg && w && (off == 8 || off == 12) && !armed;
    @(posedge clk_i);
    mcyc++;
    if (sz != 0 && ready) begin emitted.push_back(dch); void'(mq.pop_front()); end
    if (eg && prwr && b0) mq.push_back(wd[7:0]);
    if (fin) begin
      armed = 1;
      kind = (off == 12) ? 3 : ((wd == MAGIC) ? 1 : 2);
      mexit = wd;
    end
    if (armed && sz == 0) done = 1;
    #1;
    chk("rvalid", rvalid, eg);
    chk("rdata", rdata, erd);
    chk("passed", passed, done && kind == 1);
    chk("failed", failed, done && kind == 2);
    chk("exit_valid", exit_valid, done && kind == 3);
    if (done && kind == 3) chk("exit_value", exit_value, mexit);
  endtask

  task automatic do_reset();
    rst_ni = 0; req = 0; ready = 0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_stdout_valid", sv, 0);
    chk("rst_stdout_char", ch, 0);
    chk("rst_passed", passed, 0);
    chk("rst_failed", failed, 0);
    chk("rst_exit_valid", exit_valid, 0);
    chk("rst_exit_value", exit_value, 0);
    mq.delete(); emitted.delete();
    mcyc = 0; armed = 0; done = 0; kind = 0; mexit = 0;
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_ni = 1;
  endtask

  logic [31:0] offs [12] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h10, 32'h14, 32'h1C,
                             32'h20, 32'hFFFF_FFFC, 32'h8, 32'hC, 32'h0};

  initial begin
    logic [31:0] c0, c1;
    int n;
    #3;
    do_reset();

    // "Hi" with host ready
    ready = 1;
    set(1, BASE, 1, 4'h1, 32'h48); step();
    set(1, BASE, 1, 4'h1, 32'h69); step();
    set(0, BASE, 0, 4'h0, 0);
    repeat (4) step();
    chk("hi_count", emitted.size(), 2);
    if (emitted.size() >= 2) begin
      chk("hi_char0", emitted[0], 8'h48);
      chk("hi_char1", emitted[1], 8'h69);
    end

    // Fill FIFO, stall 17th write, observe STATUS full
    ready = 0;
    for (int i = 0; i < 17; i++) begin
      set(1, BASE, 1, 4'h1, 32'h41 + i); step();
    end
    chk("stall_gnt", gnt, 0);
    set(1, BASE + 4, 0, 4'h0, 0); step();
    chk("status_full", rdata, 32'h110);
    set(1, BASE, 1, 4'h1, 32'h5A); step();
    ready = 1; step();
    step();
    set(1, BASE, 1, 4'h0, 32'h77); step();  // be[0]=0: granted, not pushed
    set(0, BASE, 0, 4'h0, 0);
    repeat (20) step();

    // RESULT pass held until stdout drains
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set(1, BASE, 1, 4'h1, 32'h61 + i); step();
    end
    set(1, BASE + 8, 1, 4'hF, MAGIC); step();
    set(0, BASE, 0, 4'h0, 0);
    repeat (5) step();
    chk("pass_held", passed, 0);
    ready = 1; n = 0;
    while (!passed && n < 10) begin step(); n++; end
    chk("pass_rise", passed, 1);
    chk("pass_drained", emitted.size(), 3);
    repeat (3) step();
    chk("pass_sticky", passed, 1);

    // EXIT with empty FIFO, later RESULT ignored
    do_reset();
    set(1, BASE + 12, 1, 4'hF, 32'd5); step();
    chk("exit_valid_next", exit_valid, 1);
    chk("exit_value_next", exit_value, 32'd5);
    set(1, BASE + 8, 1, 4'hF, MAGIC); step();
    set(0, BASE, 0, 4'h0, 0);
    repeat (3) step();
    chk("exit_then_result_passed", passed, 0);
    chk("exit_sticky", exit_value, 32'd5);

    // CYCLES delta, unmapped offset, out-of-window
    set(1, BASE + 16, 0, 4'h0, 0); step(); c0 = rdata;
    set(0, BASE, 0, 4'h0, 0);
    repeat (9) step();
    set(1, BASE + 16, 0, 4'h0, 0); step(); c1 = rdata;
    chk("cycles_diff", c1 - c0, 32'd10);
    set(1, BASE + 32'h1C, 0, 4'h0, 0); step();
    chk("unmapped_rdata", rdata, 0);
    set(1, BASE + 32'h20, 0, 4'h0, 0);
    repeat (3) step();
    chk("outside_gnt", gnt, 0);

    // Reset mid-transaction with characters and exit pending
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set(1, BASE, 1, 4'h1, 32'h30 + i); step();
    end
    set(1, BASE + 12, 1, 4'hF, 32'd7); step();
    do_reset();
    set(1, BASE + 4, 0, 4'h0, 0); step();
    chk("status_after_reset", rdata, 0);

    // Random traffic
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < 250; i++) begin
        logic [31:0] d;
        int idx;
        idx = $urandom_range(0, (i < 100) ? 8 : 11);
        d = ($urandom_range(0, 1) == 1) ? MAGIC : $urandom;
        set($urandom_range(0, 3) != 0, BASE + offs[idx], $urandom_range(0, 1) == 1,
            4'($urandom), d);
        ready = $urandom_range(0, 2) == 0;
        step();
        if (r == 1 && i == 150) do_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
